// File: rtl/fp_cvt_pkg.sv
// Shared constants, rounding-mode and operand-class encodings for the FP-to-integer converter.
// Also holds the stage-1 unpack helper so the field layout lives in one place.
package fp_cvt_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;

  typedef enum logic [1:0] {
    RM_TRUNC = 2'b00,
    RM_RNE   = 2'b01,
    RM_FLOOR = 2'b10,
    RM_CEIL  = 2'b11
  } rnd_mode_t;

  typedef enum logic [1:0] {
    FC_ZERO = 2'b00,  // zero or denormal
    FC_NORM = 2'b01,
    FC_INF  = 2'b10,
    FC_NAN  = 2'b11
  } fp_class_t;

  // exp is the unbiased exponent in two's complement, range -127..128
  typedef struct packed {
    logic             sign;
    logic [9:0]       exp;
    logic [FP_FRAC_W:0] mant;
    fp_class_t        cls;
    rnd_mode_t        rnd;
  } unpacked_t;

  function automatic unpacked_t fp_unpack(input logic [31:0] fp, input logic [1:0] rnd);
    unpacked_t u;
    logic [FP_EXP_W-1:0] bexp;
    bexp   = fp[30:23];
    u.sign = fp[31];
    u.exp  = {2'b00, bexp} - 10'(FP_BIAS);
    u.mant = {bexp != 8'd0, fp[22:0]};
    if (bexp == 8'd0)
      u.cls = FC_ZERO;
    else if (bexp == 8'hFF)
      u.cls = (fp[22:0] != 23'd0) ? FC_NAN : FC_INF;
    else
      u.cls = FC_NORM;
    u.rnd = rnd_mode_t'(rnd);
    return u;
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Stage-2 combinational datapath: align the mantissa to an integer, round in the
// magnitude domain, then range-check and saturate into the INT_W-bit result.
module fp_round_sat
  import fp_cvt_pkg::*;
#(
  parameter int INT_W      = 8,
  parameter bit SIGNED_OUT = 1'b0
) (
  input  logic             sign,
  input  logic [9:0]       exp,
  input  logic [23:0]      mant,
  input  logic [1:0]       cls,
  input  logic [1:0]       rnd,
  output logic [INT_W-1:0] res,
  output logic             ovf,
  output logic             inv,
  output logic             inex
);

  localparam logic [32:0] UMAX = (33'd1 << INT_W) - 33'd1;
  localparam logic [32:0] SPOS = (33'd1 << (INT_W - 1)) - 33'd1;
  localparam logic [32:0] SNEG = 33'd1 << (INT_W - 1);
  localparam logic [INT_W-1:0] MAX_CODE = SIGNED_OUT ? SPOS[INT_W-1:0] : UMAX[INT_W-1:0];
  localparam logic [INT_W-1:0] MIN_CODE = SIGNED_OUT ? SNEG[INT_W-1:0] : '0;

  logic signed [9:0] e;
  logic [4:0]  rsh;
  logic [3:0]  lsh;
  logic [47:0] ext;
  logic [32:0] mag;
  logic [32:0] mag_r;
  logic        guard;
  logic        sticky;
  logic        big;
  logic        inc;

  assign e   = $signed(exp);
  assign rsh = 5'd23 - exp[4:0];   // 0..24 for e in -1..23
  assign lsh = exp[3:0] - 4'd7;    // 1..8 for e in 24..31

  always_comb begin
    ext    = '0;
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    big    = 1'b0;
    if (e < -1) begin
      sticky = |mant;
    end else if (e <= 23) begin
      // Mantissa sits above 24 zero bits so the shifted-out part keeps guard and sticky.
      ext    = {mant, 24'd0} >> rsh;
      mag    = {9'd0, ext[47:24]};
      guard  = ext[23];
      sticky = |ext[22:0];
    end else if (e <= 31) begin
      mag = {9'd0, mant} << lsh;
    end else begin
      big = 1'b1;
    end
  end

  always_comb begin
    inc = 1'b0;
    case (rnd_mode_t'(rnd))
      RM_TRUNC: inc = 1'b0;
      RM_RNE:   inc = guard && (sticky || mag[0]);
      RM_FLOOR: inc = sign && (guard || sticky);
      RM_CEIL:  inc = !sign && (guard || sticky);
      default:  inc = 1'b0;
    endcase
  end

  assign mag_r = mag + {32'd0, inc};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    inv = 1'b0;
    case (fp_class_t'(cls))
      FC_NAN: inv = 1'b1;
      FC_INF: begin
        ovf = 1'b1;
        res = sign ? MIN_CODE : MAX_CODE;
      end
      default: begin
        if (!SIGNED_OUT) begin
          if (sign && (big || mag_r != 33'd0)) begin
            ovf = 1'b1;
          end else if (big || mag_r > UMAX) begin
            res = MAX_CODE;
            ovf = 1'b1;
          end else begin
            res = mag_r[INT_W-1:0];
          end
        end else if (sign) begin
          if (big || mag_r > SNEG) begin
            res = MIN_CODE;
            ovf = 1'b1;
          end else begin
            res = '0 - mag_r[INT_W-1:0];
          end
        end else if (big || mag_r > SPOS) begin
          res = MAX_CODE;
          ovf = 1'b1;
        end else begin
          res = mag_r[INT_W-1:0];
        end
      end
    endcase
  end

  assign inex = guard || sticky || ovf || inv;

endmodule

// File: rtl/fp_to_int_pipe.sv
// Two-stage binary32-to-integer converter with valid/ready on both sides.
// Stage 1 registers the unpacked operand, stage 2 registers the rounded/saturated result.
module fp_to_int_pipe
  import fp_cvt_pkg::*;
#(
  parameter int INT_W      = 8,
  parameter bit SIGNED_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_fp,
  input  logic [1:0]       in_rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_int,
  output logic             out_ovf,
  output logic             out_inv,
  output logic             out_inex
);

  logic       s1_v_reg;
  unpacked_t  s1_reg;
  logic       s2_v_reg;
  logic       s1_rdy;
  logic       s2_rdy;

  logic [INT_W-1:0] res_next;
  logic             ovf_next;
  logic             inv_next;
  logic             inex_next;

  // Each stage may load whenever the stage after it is draining, so no bubbles under backpressure.
  assign s2_rdy   = !s2_v_reg || out_ready;
  assign s1_rdy   = !s1_v_reg || s2_rdy;
  assign in_ready = s1_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_reg <= 1'b0;
      s1_reg   <= '0;
    end else if (s1_rdy) begin
      s1_v_reg <= in_valid;
      if (in_valid)
        s1_reg <= fp_unpack(in_fp, in_rnd);
    end
  end

  fp_round_sat #(
    .INT_W      (INT_W),
    .SIGNED_OUT (SIGNED_OUT)
  ) u_round_sat (
    .sign (s1_reg.sign),
    .exp  (s1_reg.exp),
    .mant (s1_reg.mant),
    .cls  (s1_reg.cls),
    .rnd  (s1_reg.rnd),
    .res  (res_next),
    .ovf  (ovf_next),
    .inv  (inv_next),
    .inex (inex_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_reg <= 1'b0;
      out_int  <= '0;
      out_ovf  <= 1'b0;
      out_inv  <= 1'b0;
      out_inex <= 1'b0;
    end else if (s2_rdy) begin
      s2_v_reg <= s1_v_reg;
      if (s1_v_reg) begin
        out_int  <= res_next;
        out_ovf  <= ovf_next;
        out_inv  <= inv_next;
        out_inex <= inex_next;
      end
    end
  end

  assign out_valid = s2_v_reg;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Directed bench: an unsigned and a signed 8-bit converter share one input stream;
// results are checked against hand-computed values with immediate assertions.
module tb_fp_to_int_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_fp = 32'd0;
  logic [1:0]  in_rnd = 2'd0;

  logic       in_ready_u, out_valid_u, ovf_u, inv_u, inex_u;
  logic [7:0] int_u;
  logic       in_ready_s, out_valid_s, ovf_s, inv_s, inex_s;
  logic [7:0] int_s;

  int n_chk = 0;
  int n_pass = 0;
  logic [10:0] ru, rs;

  always #5 clk = ~clk;

  fp_to_int_pipe #(.INT_W(8), .SIGNED_OUT(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_fp(in_fp), .in_rnd(in_rnd), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_int(int_u), .out_ovf(ovf_u), .out_inv(inv_u), .out_inex(inex_u)
  );

  fp_to_int_pipe #(.INT_W(8), .SIGNED_OUT(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_fp(in_fp), .in_rnd(in_rnd), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_int(int_s), .out_ovf(ovf_s), .out_inv(inv_s), .out_inex(inex_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // One word through an empty pipeline; captures both results as {int, ovf, inv, inex}.
  task automatic run(input logic [31:0] fp, input logic [1:0] rm);
    int wait_n;
    @(negedge clk);
    in_fp = fp; in_rnd = rm; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid_u && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    if (!out_valid_u) chk("timeout", {31'd0, out_valid_u}, 32'd1);
    ru = {int_u, ovf_u, inv_u, inex_u};
    rs = {int_s, ovf_s, inv_s, inex_s};
    $display("fp=%h rnd=%0d -> uns %h ovf/inv/inex=%b, sgn %h ovf/inv/inex=%b",
             fp, rm, int_u, ru[2:0], int_s, rs[2:0]);
  endtask

  task automatic expu(input string tag, input logic [7:0] v, input logic [2:0] f);
    chk(tag, {21'd0, ru}, {21'd0, v, f});
  endtask

  task automatic exps(input string tag, input logic [7:0] v, input logic [2:0] f);
    chk(tag, {21'd0, rs}, {21'd0, v, f});
  endtask

  function automatic logic [31:0] int_to_fp(input int n);
    int p;
    logic [31:0] m;
    p = 0;
    for (int b = 0; b < 31; b++) if (((n >> b) & 1) != 0) p = b;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vals [16];
    int n_sent, n_rcv, cyc, occ;
    logic held;
    logic [10:0] held_val;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs_u", {20'd0, out_valid_u, int_u, ovf_u, inv_u, inex_u}, 32'd0);
    chk("rst_outs_s", {20'd0, out_valid_s, int_s, ovf_s, inv_s, inex_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready_u}, 32'd1);

    // Unsigned truncation
    run(32'h3F800000, 2'd0); expu("t1_1.0", 8'd1, 3'b000);
    run(32'h3FC00000, 2'd0); expu("t1_1.5", 8'd1, 3'b001);
    run(32'h42DE8000, 2'd0); expu("t1_111.25", 8'd111, 3'b001);
    run(32'h437F0000, 2'd0); expu("t1_255", 8'd255, 3'b000);

    // Rounding modes on 1.5 and 2.5
    run(32'h3FC00000, 2'd1); expu("t2_1.5_rne", 8'd2, 3'b001);
    run(32'h3FC00000, 2'd2); expu("t2_1.5_floor", 8'd1, 3'b001);
    run(32'h3FC00000, 2'd3); expu("t2_1.5_ceil", 8'd2, 3'b001);
    run(32'h40200000, 2'd0); expu("t2_2.5_trunc", 8'd2, 3'b001);
    run(32'h40200000, 2'd1); expu("t2_2.5_rne", 8'd2, 3'b001);
    run(32'h40200000, 2'd2); expu("t2_2.5_floor", 8'd2, 3'b001);
    run(32'h40200000, 2'd3); expu("t2_2.5_ceil", 8'd3, 3'b001);
    run(32'h3F000000, 2'd1); expu("t2_0.5_rne", 8'd0, 3'b001);
    run(32'h3F000000, 2'd3); expu("t2_0.5_ceil", 8'd1, 3'b001);
    run(32'h00000001, 2'd3); expu("t2_denorm_ceil", 8'd1, 3'b001);
    run(32'h00000001, 2'd0); expu("t2_denorm_trunc", 8'd0, 3'b001);

    // Saturation and special operands
    run(32'h43800000, 2'd0); expu("t3_256_u", 8'd255, 3'b101); exps("t3_256_s", 8'h7F, 3'b101);
    run(32'hBFC00000, 2'd0); expu("t3_m1.5_u", 8'd0, 3'b101); exps("t3_m1.5_s", 8'hFF, 3'b001);
    run(32'hBFC00000, 2'd2); exps("t3_m1.5_floor_s", 8'hFE, 3'b001);
    run(32'hBE99999A, 2'd0); expu("t3_m0.3_u", 8'd0, 3'b001); exps("t3_m0.3_s", 8'd0, 3'b001);
    run(32'hBE99999A, 2'd2); expu("t3_m0.3_floor_u", 8'd0, 3'b101); exps("t3_m0.3_floor_s", 8'hFF, 3'b001);
    run(32'h7F800000, 2'd0); expu("t3_pinf_u", 8'hFF, 3'b101); exps("t3_pinf_s", 8'h7F, 3'b101);
    run(32'hFF800000, 2'd0); expu("t3_ninf_u", 8'h00, 3'b101); exps("t3_ninf_s", 8'h80, 3'b101);
    run(32'h7FC00000, 2'd0); expu("t3_nan_u", 8'd0, 3'b011); exps("t3_nan_s", 8'd0, 3'b011);
    run(32'h80000000, 2'd3); expu("t3_negzero", 8'd0, 3'b000);
    run(32'h437F8000, 2'd1); expu("t3_255.5_rne_u", 8'hFF, 3'b101); exps("t3_255.5_rne_s", 8'h7F, 3'b101);
    run(32'h4F800000, 2'd0); expu("t3_2p32_u", 8'hFF, 3'b101);

    // Signed range edges
    run(32'hC3000000, 2'd0); exps("t4_m128_s", 8'h80, 3'b000); expu("t4_m128_u", 8'd0, 3'b101);
    run(32'hC3010000, 2'd0); exps("t4_m129_s", 8'h80, 3'b101);
    run(32'h43000000, 2'd0); exps("t4_128_s", 8'h7F, 3'b101); expu("t4_128_u", 8'h80, 3'b000);
    run(32'h42FE0000, 2'd0); exps("t4_127_s", 8'h7F, 3'b000);

    // Streaming with random backpressure
    for (int i = 0; i < 16; i++) vals[i] = 3 + i * 13;
    n_sent = 0; n_rcv = 0; cyc = 0; held = 1'b0; held_val = '0;
    while (n_rcv < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        chk("t5_hold", {20'd0, out_valid_u, int_u, ovf_u, inv_u, inex_u}, {20'd0, 1'b1, held_val});
        held = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (n_sent < 16);
      in_fp     = (n_sent < 16) ? int_to_fp(vals[n_sent]) : 32'd0;
      in_rnd    = 2'd0;
      #1;
      occ = n_sent - n_rcv;
      chk("t5_in_ready", {31'd0, in_ready_u}, {31'd0, !(occ == 2 && !out_ready)});
      if (out_valid_u && out_ready) begin
        chk("t5_data", {21'd0, int_u, ovf_u, inv_u, inex_u}, {21'd0, 8'(vals[n_rcv]), 3'b000});
        $display("stream word %0d -> %0d", n_rcv, int_u);
        n_rcv++;
      end else if (out_valid_u) begin
        held = 1'b1;
        held_val = {int_u, ovf_u, inv_u, inex_u};
      end
      if (in_valid && in_ready_u) n_sent++;
    end
    in_valid = 1'b0;
    chk("t5_count", 32'(n_rcv), 32'd16);

    // Reset with two words in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_fp = int_to_fp(7); in_rnd = 2'd0;
    @(negedge clk);
    in_fp = int_to_fp(9);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_pre_full", {30'd0, out_valid_u, in_ready_u}, {30'd0, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {30'd0, out_valid_u, out_valid_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_stale", {31'd0, out_valid_u}, 32'd0);
    end
    in_valid = 1'b1; in_fp = int_to_fp(42);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_lat1", {31'd0, out_valid_u}, 32'd0);
    @(negedge clk);
    chk("t6_lat2", {23'd0, out_valid_u, int_u}, {23'd0, 1'b1, 8'd42});
    $display("post-reset word -> %0d", int_u);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
